// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register map, CTRL/STAT bit
// positions, reset constants and the byte-lane write merge.
package timer_pkg;

  // Register index as decoded from addr[3:2]
  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_COUNT = 2'd1,
    REG_CMP   = 2'd2,
    REG_STAT  = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_PEND = 0;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: one-cycle tick every div cycles while en is high; the phase
// counter is forced to 0 whenever en is low.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        wrap;

  assign wrap = (cnt_q == div - 16'd1);
  assign tick = en & wrap;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped compare timer: CTRL/COUNT/CMP/STAT registers behind a simple
// CPU data-bus strobe, with a level interrupt on compare match.
module mmio_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq
);

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pend_q, pend_d;
  logic        hit, wr, tick, match;
  logic [31:0] rdata;
  reg_sel_e    rsel;
  logic [1:0]  unused_addr;

  assign unused_addr = addr[1:0];
  assign hit   = ce && (addr[31:4] == BASE_ADDR[31:4]);
  assign wr    = hit && we;
  assign rsel  = reg_sel_e'(addr[3:2]);
  assign match = (count_q == cmp_q);

  timer_prescaler u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .div   (16'(PRESCALE)),
    .tick  (tick)
  );

  // Tick result first; a CPU write then overrides only its enabled bytes
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    pend_d  = pend_q;
    if (tick) begin
      count_d = (match && ctrl_q[CTRL_AUTO]) ? '0 : count_q + 32'd1;
    end
    if (wr) begin
      case (rsel)
        REG_CTRL:  if (sel[0]) ctrl_d = data_i[2:0];
        REG_COUNT: count_d = byte_merge(count_d, data_i, sel);
        REG_CMP:   cmp_d   = byte_merge(cmp_q, data_i, sel);
        REG_STAT:  if (sel[0] && data_i[STAT_PEND]) pend_d = 1'b0;
      endcase
    end
    // A match tick wins over a simultaneous W1C
    if (tick && match) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      count_q <= '0;
      cmp_q   <= CMP_RESET;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (rsel)
      REG_CTRL:  rdata[2:0] = ctrl_q;
      REG_COUNT: rdata = count_q;
      REG_CMP:   rdata = cmp_q;
      REG_STAT:  rdata[STAT_PEND] = pend_q;
    endcase
  end

  // CMP resets to all-ones, so reset must gate the read path explicitly
  assign data_o = (hit && !we && !reset) ? rdata : '0;
  assign irq    = pend_q & ctrl_q[CTRL_IE];

endmodule
